prog_sequencer: RTL and testbench
=================================

Name: prog_sequencer

Overview:
- Control FSM that sequences the program counter for the custom-ISA core.
- Arms on Start, launches the selected program by loading its base address, and advances the PC each cycle.
- Resolves branch requests from decode against ALU_flag and drives the PC load/target.
- Terminates on halt, cycle-budget expiry or PC overrun, and reports Done, Timeout and Fault.

Parameters:
- PC_W, 10, program counter / branch target width
- NUM_PROGS, 3, number of selectable programs; base addresses come from the shared package
- CYC_W, 16, cycle counter width
- MAX_CYCLES, 16'hFFFF, run-cycle budget before forced timeout

Ports:
- Clk  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-low reset
- Start  in  1  level; PC held while high, launch on deassertion
- ProgSel  in  2  program index, sampled on the cycle Start falls
- HaltDecoded  in  1  decode saw a halt instruction (valid in RUN)
- BranchReq  in  1  decode has a branch this cycle
- BranchCond  in  1  0 = unconditional, 1 = taken only if ALU_flag = 1
- ALU_flag  in  1  ALU condition flag
- BranchTarget  in  PC_W  absolute branch target
- PcCurrent  in  PC_W  current PC value fed back from the program counter
- PcEnable  out  1  PC advances by 1 this cycle
- PcLoad  out  1  PC loads PcTarget this cycle; overrides PcEnable
- PcTarget  out  PC_W  load value
- Busy  out  1  high in LAUNCH and RUN
- Done  out  1  level, high in DONE
- Timeout  out  1  sticky; run ended by cycle budget
- Fault  out  1  sticky; bad ProgSel or PC overrun
- CycleCount  out  CYC_W  RUN cycles of the current or last run, saturating

Behaviour:
- Reset (async, Reset = 0): state IDLE; all outputs 0; CycleCount 0; latched program 0.
- States: IDLE, ARMED, LAUNCH, RUN, DONE.
- IDLE:
  - Start = 1 -> ARMED.
  - Outputs PcEnable = 0, PcLoad = 0.
- ARMED:
  - PC is held: PcEnable = 0, PcLoad = 0.
  - Start = 0 -> latch ProgSel.
  - ProgSel >= NUM_PROGS -> DONE with Fault = 1.
  - Otherwise -> LAUNCH, and clear Timeout, Fault and CycleCount.
- LAUNCH (one cycle):
  - PcLoad = 1 and PcTarget = base[latched]. The PC shows the base on the next cycle.
  - Next state RUN.
- RUN, evaluated each cycle in priority order:
  1. Start = 1 -> ARMED (abort); no PC change this cycle.
  2. HaltDecoded -> DONE; PcEnable = 0; halt takes priority over a same-cycle branch.
  3. Branch taken (BranchReq and (!BranchCond or ALU_flag)) -> PcLoad = 1, PcTarget = BranchTarget. This is combinational, with zero-cycle latency to the PC input.
  4. Otherwise PcEnable = 1. If PcCurrent is all ones -> DONE with Fault = 1, and PcEnable is suppressed (no wrap to 0).
- RUN counting:
  - CycleCount increments on every cycle spent in RUN and saturates at all ones.
  - When CycleCount reaches MAX_CYCLES-1 and no halt occurs, the next state is DONE with Timeout = 1.
  - Timeout has lower priority than halt, higher than branch.
- DONE:
  - Done = 1; PC is held.
  - Start = 1 -> ARMED.
  - Timeout and Fault hold until the next launch.
- PcTarget = 0 whenever PcLoad = 0.
- Reset mid-run: immediate return to IDLE; outputs cleared asynchronously.

Decomposition:
- Package prog_seq_pkg contains:
  - the state enum seq_state_t;
  - the constant array PROG_BASE[NUM_PROGS] = {10'd0, 10'd256, 10'd512};
  - the branch-resolve function branch_taken().
- One sub-module is natural: cycle_budget_ctr, holding the saturating counter and the budget compare.

Test Plan:
- Reset = 0 mid-RUN: all outputs go to 0 immediately. Release Reset, Start = 0 for 3 cycles -> stays IDLE, PcEnable = 0.
- Start = 1 for 2 cycles, then 0 with ProgSel = 1:
  - one cycle PcLoad = 1, PcTarget = 256;
  - then PcEnable = 1 and Busy = 1;
  - CycleCount = 3 after 3 RUN cycles.
- In RUN:
  - BranchReq = 1, BranchCond = 1, ALU_flag = 0 -> PcEnable = 1, PcLoad = 0.
  - ALU_flag = 1, BranchTarget = 10 -> PcLoad = 1, PcTarget = 10.
  - BranchCond = 0 -> taken regardless of ALU_flag.
- HaltDecoded = 1 with BranchReq = 1 in the same cycle -> PcLoad = 0, next cycle Done = 1, Busy = 0, Timeout = 0.
- MAX_CYCLES = 8 variant, no halt -> Done = 1 and Timeout = 1 after 8 RUN cycles, CycleCount = 8. A new Start launch clears Timeout.
- Fault checks:
  - ProgSel = 3 at Start fall -> DONE with Fault = 1 and no PcLoad.
  - In RUN with PcCurrent = 10'h3FF and no branch -> Fault = 1, PcEnable = 0.

Source files
------------

// File: rtl/prog_seq_pkg.sv
// prog_seq_pkg: shared types and constants for the program sequencer.
//   seq_state_t   - sequencer FSM states
//   PROG_BASE     - base address of each selectable program
//   branch_taken  - resolves a decode branch request against the ALU flag
//   prog_base     - safe lookup of PROG_BASE by program index
package prog_seq_pkg;

    localparam int unsigned SEQ_PC_W      = 10;
    localparam int unsigned SEQ_NUM_PROGS = 3;

    typedef enum logic [2:0] {
        StIdle,
        StArmed,
        StLaunch,
        StRun,
        StDone
    } seq_state_t;

    localparam logic [SEQ_PC_W-1:0] PROG_BASE [SEQ_NUM_PROGS] = '{10'd0, 10'd256, 10'd512};

    // cond = 0: unconditional; cond = 1: taken only when the ALU flag is set
    function automatic logic branch_taken(input logic req, input logic cond, input logic flag);
        return req && (!cond || flag);
    endfunction

    // Out-of-range indices return 0 rather than reading past the table
    function automatic logic [SEQ_PC_W-1:0] prog_base(input logic [1:0] sel);
        logic [SEQ_PC_W-1:0] base;
        base = '0;
        for (int i = 0; i < int'(SEQ_NUM_PROGS); i++) begin
            if (int'(sel) == i) base = PROG_BASE[i];
        end
        return base;
    endfunction

endpackage

// File: rtl/cycle_budget_ctr.sv
// cycle_budget_ctr: saturating RUN-cycle counter with run-budget compare.
//   i_clk, i_rst_n  - clock, asynchronous active-low reset
//   i_clear         - synchronous clear (new launch)
//   i_count         - count this cycle (sequencer is in RUN)
//   o_count         - current count, saturates at all ones
//   o_budget_hit    - count has reached MAX_CYCLES-1: this RUN cycle is the last
module cycle_budget_ctr #(
    parameter int unsigned      CYC_W      = 16,
    parameter logic [CYC_W-1:0] MAX_CYCLES = 16'hFFFF
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clear,
    input  logic             i_count,
    output logic [CYC_W-1:0] o_count,
    output logic             o_budget_hit
);

    localparam logic [CYC_W-1:0] LAST_CYCLE = MAX_CYCLES - CYC_W'(1);

    logic [CYC_W-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_count && (r_count != '1)) begin
            r_count <= r_count + CYC_W'(1);
        end
    end

    assign o_count      = r_count;
    assign o_budget_hit = (r_count == LAST_CYCLE);

endmodule

// File: rtl/prog_sequencer.sv
// prog_sequencer: control FSM sequencing the program counter of the core.
//   i_clk, i_rst_n        - clock, asynchronous active-low reset
//   i_start, i_prog_sel   - arm while high; launch program i_prog_sel when it falls
//   i_halt_decoded        - decode saw a halt
//   i_branch_req/_cond    - decode branch request and its condition mode
//   i_alu_flag            - ALU condition flag
//   i_branch_target       - absolute branch target
//   i_pc_current          - PC fed back from the program counter
//   o_pc_enable/o_pc_load - PC increment / load (load wins)
//   o_pc_target           - load value, 0 when not loading
//   o_busy, o_done        - in LAUNCH/RUN, in DONE
//   o_timeout, o_fault    - sticky run-end causes, cleared on the next launch
//   o_cycle_count         - RUN cycles of the current or last run
module prog_sequencer
    import prog_seq_pkg::*;
#(
    parameter int unsigned      PC_W       = SEQ_PC_W,
    parameter int unsigned      NUM_PROGS  = SEQ_NUM_PROGS,
    parameter int unsigned      CYC_W      = 16,
    parameter logic [CYC_W-1:0] MAX_CYCLES = 16'hFFFF
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [1:0]       i_prog_sel,
    input  logic             i_halt_decoded,
    input  logic             i_branch_req,
    input  logic             i_branch_cond,
    input  logic             i_alu_flag,
    input  logic [PC_W-1:0]  i_branch_target,
    input  logic [PC_W-1:0]  i_pc_current,
    output logic             o_pc_enable,
    output logic             o_pc_load,
    output logic [PC_W-1:0]  o_pc_target,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_timeout,
    output logic             o_fault,
    output logic [CYC_W-1:0] o_cycle_count
);

    seq_state_t r_state, w_state_next;
    logic [1:0] r_prog;
    logic       r_timeout, r_fault;

    logic w_latch, w_launch, w_set_timeout, w_set_fault, w_count, w_budget_hit;

    cycle_budget_ctr #(
        .CYC_W      (CYC_W),
        .MAX_CYCLES (MAX_CYCLES)
    ) u_budget (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_clear      (w_launch),
        .i_count      (w_count),
        .o_count      (o_cycle_count),
        .o_budget_hit (w_budget_hit)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= StIdle;
            r_prog    <= '0;
            r_timeout <= 1'b0;
            r_fault   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_latch) r_prog <= i_prog_sel;
            if (w_launch) begin
                r_timeout <= 1'b0;
                r_fault   <= 1'b0;
            end
            if (w_set_timeout) r_timeout <= 1'b1;
            if (w_set_fault)   r_fault   <= 1'b1;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_latch       = 1'b0;
        w_launch      = 1'b0;
        w_set_timeout = 1'b0;
        w_set_fault   = 1'b0;
        w_count       = 1'b0;
        o_pc_enable   = 1'b0;
        o_pc_load     = 1'b0;
        o_pc_target   = '0;
        o_busy        = 1'b0;
        o_done        = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (i_start) w_state_next = StArmed;
            end
            StArmed: begin
                if (!i_start) begin
                    w_latch = 1'b1;
                    if (32'(i_prog_sel) >= NUM_PROGS) begin
                        w_state_next = StDone;
                        w_set_fault  = 1'b1;
                    end else begin
                        w_state_next = StLaunch;
                        w_launch     = 1'b1;
                    end
                end
            end
            StLaunch: begin
                o_busy       = 1'b1;
                o_pc_load    = 1'b1;
                o_pc_target  = PC_W'(prog_base(r_prog));
                w_state_next = StRun;
            end
            StRun: begin
                o_busy  = 1'b1;
                w_count = 1'b1;
                if (i_start) begin
                    w_state_next = StArmed;
                end else if (i_halt_decoded) begin
                    w_state_next = StDone;
                end else if (w_budget_hit) begin
                    // Budget exhausted: run ends here, a same-cycle branch is dropped
                    w_state_next  = StDone;
                    w_set_timeout = 1'b1;
                end else if (branch_taken(i_branch_req, i_branch_cond, i_alu_flag)) begin
                    o_pc_load   = 1'b1;
                    o_pc_target = i_branch_target;
                end else if (&i_pc_current) begin
                    // Incrementing would wrap to 0: stop instead
                    w_state_next = StDone;
                    w_set_fault  = 1'b1;
                end else begin
                    o_pc_enable = 1'b1;
                end
            end
            StDone: begin
                o_done = 1'b1;
                if (i_start) w_state_next = StArmed;
            end
            default: w_state_next = StIdle;
        endcase
    end

    assign o_timeout = r_timeout;
    assign o_fault   = r_fault;

endmodule

// File: tb/tb_prog_sequencer.sv
// Self-checking bench for prog_sequencer: a default-budget instance and an
// 8-cycle-budget instance share all inputs.
module tb_prog_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  prog_sel;
    logic        halt, br_req, br_cond, alu;
    logic [9:0]  br_target;
    logic [9:0]  pc;

    logic        o_pc_enable, o_pc_load, o_busy, o_done, o_timeout, o_fault;
    logic [9:0]  o_pc_target;
    logic [15:0] o_cycle_count;

    logic        s_pc_enable, s_pc_load, s_busy, s_done, s_timeout, s_fault;
    logic [9:0]  s_pc_target;
    logic [15:0] s_cycle_count;

    int checks = 0;
    int errors = 0;

    logic [9:0] bases [3] = '{10'd0, 10'd256, 10'd512};

    always #5 clk = ~clk;

    prog_sequencer dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_start         (start),
        .i_prog_sel      (prog_sel),
        .i_halt_decoded  (halt),
        .i_branch_req    (br_req),
        .i_branch_cond   (br_cond),
        .i_alu_flag      (alu),
        .i_branch_target (br_target),
        .i_pc_current    (pc),
        .o_pc_enable     (o_pc_enable),
        .o_pc_load       (o_pc_load),
        .o_pc_target     (o_pc_target),
        .o_busy          (o_busy),
        .o_done          (o_done),
        .o_timeout       (o_timeout),
        .o_fault         (o_fault),
        .o_cycle_count   (o_cycle_count)
    );

    prog_sequencer #(
        .MAX_CYCLES (16'd8)
    ) dut_short (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_start         (start),
        .i_prog_sel      (prog_sel),
        .i_halt_decoded  (halt),
        .i_branch_req    (br_req),
        .i_branch_cond   (br_cond),
        .i_alu_flag      (alu),
        .i_branch_target (br_target),
        .i_pc_current    (pc),
        .o_pc_enable     (s_pc_enable),
        .o_pc_load       (s_pc_load),
        .o_pc_target     (s_pc_target),
        .o_busy          (s_busy),
        .o_done          (s_done),
        .o_timeout       (s_timeout),
        .o_fault         (s_fault),
        .o_cycle_count   (s_cycle_count)
    );

    // Advance one clock; the bench's PC register follows the main DUT's commands.
    task automatic tick();
        logic       ld, en;
        logic [9:0] tgt;
        ld  = o_pc_load;
        en  = o_pc_enable;
        tgt = o_pc_target;
        @(posedge clk);
        #1;
        if (ld) pc = tgt;
        else if (en) pc = pc + 10'd1;
    endtask

    task automatic clear_decode();
        halt = 1'b0; br_req = 1'b0; br_cond = 1'b0; alu = 1'b0; br_target = '0;
    endtask

    // Leaves both instances in LAUNCH (from IDLE, RUN or DONE).
    task automatic launch(input logic [1:0] sel);
        start = 1'b1;
        tick();
        start    = 1'b0;
        prog_sel = sel;
        tick();
    endtask

    task automatic test_reset();
        launch(2'd0);
        tick();
        tick();
        tick();
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (o_pc_enable !== 1'b0) begin errors++; $display("FAIL rst_pc_enable: got %b expected 0", o_pc_enable); end
        checks++; if (o_pc_load !== 1'b0) begin errors++; $display("FAIL rst_pc_load: got %b expected 0", o_pc_load); end
        checks++; if (o_pc_target !== 10'd0) begin errors++; $display("FAIL rst_pc_target: got %0d expected 0", o_pc_target); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", o_busy); end
        checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b expected 0", o_done); end
        checks++; if ({o_timeout, o_fault} !== 2'b00) begin errors++; $display("FAIL rst_flags: got %b expected 00", {o_timeout, o_fault}); end
        checks++; if (o_cycle_count !== 16'd0) begin errors++; $display("FAIL rst_count: got %0d expected 0", o_cycle_count); end
        tick();
        rst_n = 1'b1;
        pc    = '0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (o_pc_enable !== 1'b0 || o_busy !== 1'b0) begin errors++; $display("FAIL idle_hold: got en=%b busy=%b expected en=0 busy=0", o_pc_enable, o_busy); end
            tick();
        end
    endtask

    task automatic test_launch();
        start = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if (o_pc_enable !== 1'b0 || o_pc_load !== 1'b0) begin errors++; $display("FAIL armed_hold: got en=%b ld=%b expected 0 0", o_pc_enable, o_pc_load); end
            tick();
        end
        start    = 1'b0;
        prog_sel = 2'd1;
        tick();
        #1;
        checks++; if (o_pc_load !== 1'b1 || o_pc_target !== 10'd256) begin errors++; $display("FAIL launch_load: got ld=%b tgt=%0d expected ld=1 tgt=256", o_pc_load, o_pc_target); end
        tick();
        checks++; if (pc !== 10'd256) begin errors++; $display("FAIL launch_pc: got %0d expected 256", pc); end
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (o_pc_enable !== 1'b1 || o_busy !== 1'b1) begin errors++; $display("FAIL run_enable: got en=%b busy=%b expected 1 1", o_pc_enable, o_busy); end
            tick();
        end
        #1;
        checks++; if (o_cycle_count !== 16'd3) begin errors++; $display("FAIL run_count3: got %0d expected 3", o_cycle_count); end
    endtask

    // Random branch traffic in RUN against the branch rule; first three cycles directed.
    task automatic test_branch();
        logic [1:0] sel;
        logic       taken;
        int         m_count;
        sel = 2'($urandom_range(0, 2));
        launch(sel);
        #1;
        checks++; if (o_pc_load !== 1'b1 || o_pc_target !== bases[sel]) begin errors++; $display("FAIL br_launch: got ld=%b tgt=%0d expected ld=1 tgt=%0d", o_pc_load, o_pc_target, bases[sel]); end
        tick();
        m_count = 0;
        for (int i = 0; i < 40; i++) begin
            case (i)
                0: begin br_req = 1; br_cond = 1; alu = 0; br_target = 10'd10; end
                1: begin br_req = 1; br_cond = 1; alu = 1; br_target = 10'd10; end
                2: begin br_req = 1; br_cond = 0; alu = 0; br_target = 10'd77; end
                default: begin
                    br_req    = 1'($urandom_range(0, 1));
                    br_cond   = 1'($urandom_range(0, 1));
                    alu       = 1'($urandom_range(0, 1));
                    br_target = 10'($urandom_range(0, 900));
                end
            endcase
            taken = br_req && (!br_cond || alu);
            #1;
            checks++; if (o_pc_load !== taken) begin errors++; $display("FAIL br_load[%0d]: got %b expected %b", i, o_pc_load, taken); end
            checks++; if (o_pc_target !== (taken ? br_target : 10'd0)) begin errors++; $display("FAIL br_target[%0d]: got %0d expected %0d", i, o_pc_target, taken ? br_target : 10'd0); end
            checks++; if (o_pc_enable !== !taken) begin errors++; $display("FAIL br_enable[%0d]: got %b expected %b", i, o_pc_enable, !taken); end
            checks++; if (o_cycle_count !== 16'(m_count) || o_busy !== 1'b1) begin errors++; $display("FAIL br_count[%0d]: got cnt=%0d busy=%b expected cnt=%0d busy=1", i, o_cycle_count, o_busy, m_count); end
            tick();
            m_count++;
        end
        clear_decode();
    endtask

    task automatic test_halt();
        launch(2'd2);
        tick();
        tick();
        halt = 1; br_req = 1; br_cond = 0; br_target = 10'd99;
        #1;
        checks++; if (o_pc_load !== 1'b0 || o_pc_enable !== 1'b0 || o_pc_target !== 10'd0) begin errors++; $display("FAIL halt_pc: got ld=%b en=%b tgt=%0d expected 0 0 0", o_pc_load, o_pc_enable, o_pc_target); end
        tick();
        clear_decode();
        #1;
        checks++; if (o_done !== 1'b1 || o_busy !== 1'b0 || o_timeout !== 1'b0) begin errors++; $display("FAIL halt_done: got done=%b busy=%b to=%b expected 1 0 0", o_done, o_busy, o_timeout); end
        checks++; if (o_pc_enable !== 1'b0 || o_pc_load !== 1'b0) begin errors++; $display("FAIL done_hold: got en=%b ld=%b expected 0 0", o_pc_enable, o_pc_load); end
        checks++; if (o_cycle_count !== 16'd2) begin errors++; $display("FAIL halt_count: got %0d expected 2", o_cycle_count); end
    endtask

    task automatic test_abort();
        launch(2'd1);
        tick();
        start = 1'b1;
        #1;
        checks++; if (o_pc_enable !== 1'b0 || o_pc_load !== 1'b0) begin errors++; $display("FAIL abort_pc: got en=%b ld=%b expected 0 0", o_pc_enable, o_pc_load); end
        tick();
        #1;
        checks++; if (o_busy !== 1'b0 || o_done !== 1'b0) begin errors++; $display("FAIL abort_armed: got busy=%b done=%b expected 0 0", o_busy, o_done); end
        start    = 1'b0;
        prog_sel = 2'd0;
        tick();
        #1;
        checks++; if (o_pc_load !== 1'b1 || o_pc_target !== 10'd0 || o_cycle_count !== 16'd0) begin errors++; $display("FAIL abort_relaunch: got ld=%b tgt=%0d cnt=%0d expected 1 0 0", o_pc_load, o_pc_target, o_cycle_count); end
        tick();
    endtask

    task automatic test_timeout();
        clear_decode();
        launch(2'd0);
        tick();
        for (int k = 0; k < 8; k++) begin
            #1;
            checks++; if (s_done !== 1'b0 || s_cycle_count !== 16'(k)) begin errors++; $display("FAIL to_running[%0d]: got done=%b cnt=%0d expected 0 %0d", k, s_done, s_cycle_count, k); end
            tick();
        end
        #1;
        checks++; if (s_done !== 1'b1 || s_timeout !== 1'b1) begin errors++; $display("FAIL to_end: got done=%b to=%b expected 1 1", s_done, s_timeout); end
        checks++; if (s_cycle_count !== 16'd8 || s_busy !== 1'b0) begin errors++; $display("FAIL to_count: got cnt=%0d busy=%b expected 8 0", s_cycle_count, s_busy); end
        checks++; if (o_done !== 1'b0 || o_cycle_count !== 16'd8) begin errors++; $display("FAIL to_long_budget: got done=%b cnt=%0d expected 0 8", o_done, o_cycle_count); end
        tick();
        #1;
        checks++; if (s_timeout !== 1'b1) begin errors++; $display("FAIL to_sticky: got %b expected 1", s_timeout); end
        launch(2'd1);
        #1;
        checks++; if (s_timeout !== 1'b0 || s_pc_load !== 1'b1 || s_cycle_count !== 16'd0) begin errors++; $display("FAIL to_clear: got to=%b ld=%b cnt=%0d expected 0 1 0", s_timeout, s_pc_load, s_cycle_count); end
        tick();
    endtask

    task automatic test_fault();
        clear_decode();
        start = 1'b1;
        tick();
        start    = 1'b0;
        prog_sel = 2'd3;
        #1;
        checks++; if (o_pc_load !== 1'b0) begin errors++; $display("FAIL badsel_noload: got %b expected 0", o_pc_load); end
        tick();
        #1;
        checks++; if (o_done !== 1'b1 || o_fault !== 1'b1) begin errors++; $display("FAIL badsel_fault: got done=%b fault=%b expected 1 1", o_done, o_fault); end
        checks++; if (o_pc_load !== 1'b0 || o_busy !== 1'b0) begin errors++; $display("FAIL badsel_idle_pc: got ld=%b busy=%b expected 0 0", o_pc_load, o_busy); end
        launch(2'd2);
        #1;
        checks++; if (o_fault !== 1'b0 || o_pc_target !== 10'd512) begin errors++; $display("FAIL fault_clear: got fault=%b tgt=%0d expected 0 512", o_fault, o_pc_target); end
        tick();
        pc = 10'h3FF;
        #1;
        checks++; if (o_pc_enable !== 1'b0 || o_pc_load !== 1'b0) begin errors++; $display("FAIL overrun_pc: got en=%b ld=%b expected 0 0", o_pc_enable, o_pc_load); end
        tick();
        #1;
        checks++; if (o_fault !== 1'b1 || o_done !== 1'b1 || pc !== 10'h3FF) begin errors++; $display("FAIL overrun_fault: got fault=%b done=%b pc=%0h expected 1 1 3ff", o_fault, o_done, pc); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got time limit expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        prog_sel = '0;
        pc       = '0;
        clear_decode();
        #1;
        checks++; if ({o_pc_enable, o_pc_load, o_busy, o_done, o_timeout, o_fault} !== 6'b0) begin errors++; $display("FAIL por_outputs: got %b expected 000000", {o_pc_enable, o_pc_load, o_busy, o_done, o_timeout, o_fault}); end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        test_reset();
        test_launch();
        test_branch();
        test_halt();
        test_abort();
        test_timeout();
        test_fault();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
